adbg_or1k_spr_arb: RTL

ADBG_OR1K_SPR_ARB -- requirements
Module: adbg_or1k_spr_arb

---
 rtl/adbg_or1k_spr_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/adbg_or1k_spr_arb.sv
// Round-robin arbiter that routes SPR accesses from several debug requesters to the OR1K core SPR ports.
// Only one access is in flight. Each access ends with an ack pulse, or with an err pulse for an invalid core or a timeout.
module adbg_or1k_spr_arb #(
    parameter int NB_REQ   = 2,
    parameter int NB_CORES = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                     cpu_clk_i,
    input  logic                     cpu_rstn_i,
    input  logic [NB_REQ-1:0]        req_stb_i,
    input  logic [NB_REQ-1:0]        req_we_i,
    input  logic [NB_REQ*4-1:0]      req_core_i,
    input  logic [NB_REQ*16-1:0]     req_addr_i,
    input  logic [NB_REQ*32-1:0]     req_data_i,
    output logic [31:0]              req_data_o,
    output logic [NB_REQ-1:0]        req_ack_o,
    output logic [NB_REQ-1:0]        req_err_o,
    output logic [NB_CORES*16-1:0]   cpu_addr_o,
    output logic [NB_CORES*32-1:0]   cpu_data_o,
    output logic [NB_CORES-1:0]      cpu_stb_o,
    output logic [NB_CORES-1:0]      cpu_we_o,
    input  logic [NB_CORES*32-1:0]   cpu_data_i,
    input  logic [NB_CORES-1:0]      cpu_ack_i
);

    localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, grant_q, grant_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NB_REQ-1:0] ack_d, err_d;
    logic [31:0]     rdata_d;
    logic            load;
    logic            we_q;
    logic [3:0]      core_q, gcore;
    logic [15:0]     addr_q;
    logic [31:0]     data_q;
    logic            sel_ack;
    logic [31:0]     sel_data;
    int              idx;
    logic            found;

    // The first requester that is strobing, searched from the round-robin pointer upward.
    always_comb begin
        found   = 1'b0;
        grant_d = ptr_q;
        idx     = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NB_REQ;
            if (!found && req_stb_i[idx]) begin
                found   = 1'b1;
                grant_d = PW'(idx);
            end
        end
        gcore = req_core_i[int'(grant_d)*4 +: 4];
    end

    // Ack and read data from the selected core only.
    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            if (int'(core_q) == c) begin
                sel_ack  = cpu_ack_i[c];
                sel_data = cpu_data_i[c*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = req_data_o;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    if (int'(gcore) >= NB_CORES) begin
                        err_d[grant_d] = 1'b1;
                        state_d        = RELEASE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    ack_d[grant_q] = 1'b1;
                    if (!we_q) rdata_d = sel_data;
                    state_d = RELEASE;
                end else if (cnt_q == 8'(TIMEOUT-1)) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                ptr_d   = (grant_q == PW'(NB_REQ-1)) ? '0 : grant_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            we_q       <= 1'b0;
            core_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            req_data_o <= '0;
            req_ack_o  <= '0;
            req_err_o  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            req_data_o <= rdata_d;
            req_ack_o  <= ack_d;
            req_err_o  <= err_d;
            if (load) begin
                grant_q <= grant_d;
                we_q    <= req_we_i[grant_d];
                core_q  <= gcore;
                addr_q  <= req_addr_i[int'(grant_d)*16 +: 16];
                data_q  <= req_data_i[int'(grant_d)*32 +: 32];
            end
        end
    end

    // The core ports are driven from state only, so reset silences them at once.
    always_comb begin
        cpu_stb_o  = '0;
        cpu_we_o   = '0;
        cpu_addr_o = '0;
        cpu_data_o = '0;
        if (state_q == ACCESS) begin
            for (int c = 0; c < NB_CORES; c++) begin
                if (int'(core_q) == c) begin
                    cpu_stb_o[c]           = 1'b1;
                    cpu_we_o[c]            = we_q;
                    cpu_addr_o[c*16 +: 16] = addr_q;
                    cpu_data_o[c*32 +: 32] = data_q;
                end
            end
        end
    end

endmodule
